// File: rtl/rnf_req_tracker.sv
// RN-F outstanding read tracker: allocates TxnIDs, issues REQ flits, collects CompData, returns CompAck.
// Optional per-slot WAIT_DATA watchdog is built when RNF_TRACKER_TIMEOUT_EN is defined.
package rnf_pkg;
  localparam int NODEID_W    = 7;
  localparam int TXNID_W     = 8;
  localparam int FLIT_ADDR_W = 48;
  localparam int DATA_W      = 64;
  localparam logic [6:0] REQ_READSHARED = 7'h01;
  localparam logic [4:0] RSP_COMPACK    = 5'h02;

  typedef struct packed {
    logic [TXNID_W-1:0]     txnid;
    logic [NODEID_W-1:0]    srcid;
    logic [NODEID_W-1:0]    tgtid;
    logic [6:0]             opcode;
    logic [FLIT_ADDR_W-1:0] addr;
  } reqflit_t;

  typedef struct packed {
    logic [TXNID_W-1:0]  txnid;
    logic [NODEID_W-1:0] srcid;
    logic [NODEID_W-1:0] tgtid;
    logic [DATA_W-1:0]   data;
  } datflit_t;

  typedef struct packed {
    logic [TXNID_W-1:0]  txnid;
    logic [NODEID_W-1:0] srcid;
    logic [NODEID_W-1:0] tgtid;
    logic [4:0]          opcode;
  } rspflit_t;
endpackage

module rnf_req_tracker
  import rnf_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int NODE_ID        = 0,
  parameter int HNF_ID         = 1,
  parameter int ADDR_W         = 48,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_in_valid,
  output logic                     req_in_ready,
  input  logic [ADDR_W-1:0]        req_in_addr,
  input  logic [6:0]               req_in_opcode,
  output logic                     txreq_valid,
  input  logic                     txreq_ready,
  output reqflit_t                 txreq_flit,
  input  logic                     rxdat_valid,
  input  datflit_t                 rxdat_flit,
  output logic                     txrsp_valid,
  input  logic                     txrsp_ready,
  output rspflit_t                 txrsp_flit,
  output logic                     done_valid,
  output logic [$clog2(DEPTH)-1:0] done_txnid,
  output logic [DATA_W-1:0]        done_data,
  output logic                     tracker_full,
  output logic                     tracker_empty,
  output logic                     proto_err,
  output logic                     timeout_err
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND_REQ, S_WAIT_DATA, S_SEND_ACK} slot_state_e;

  slot_state_e       state_q  [DEPTH];
  logic [ADDR_W-1:0] addr_q   [DEPTH];
  logic [6:0]        opcode_q [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];

  logic [DEPTH-1:0] idle_vec, sreq_vec, wait_vec, sack_vec;
  logic [IDX_W-1:0] alloc_idx, req_idx, ack_idx, dat_idx;
  logic             alloc_fire, req_fire, ack_fire, dat_in_range, dat_hit;
  logic             proto_err_q, done_valid_q;
  logic [IDX_W-1:0] done_txnid_q;
  logic [DATA_W-1:0] done_data_q;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_vec
      assign idle_vec[gi] = (state_q[gi] == S_IDLE);
      assign sreq_vec[gi] = (state_q[gi] == S_SEND_REQ);
      assign wait_vec[gi] = (state_q[gi] == S_WAIT_DATA);
      assign sack_vec[gi] = (state_q[gi] == S_SEND_ACK);
    end
  endgenerate

  // Lowest-index winners; scanning downward lets the last hit be the smallest index.
  always_comb begin
    alloc_idx = '0;
    req_idx   = '0;
    ack_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (idle_vec[i]) alloc_idx = IDX_W'(i);
      if (sreq_vec[i]) req_idx   = IDX_W'(i);
      if (sack_vec[i]) ack_idx   = IDX_W'(i);
    end
  end

  assign tracker_full  = ~|idle_vec;
  assign tracker_empty = &idle_vec;
  assign req_in_ready  = ~tracker_full;
  assign txreq_valid   = |sreq_vec;
  assign txrsp_valid   = |sack_vec;

  assign alloc_fire   = req_in_valid && req_in_ready;
  assign req_fire     = txreq_valid && txreq_ready;
  assign ack_fire     = txrsp_valid && txrsp_ready;
  assign dat_in_range = (rxdat_flit.txnid < TXNID_W'(DEPTH));
  assign dat_idx      = IDX_W'(rxdat_flit.txnid);
  assign dat_hit      = rxdat_valid && dat_in_range && wait_vec[dat_idx];

  always_comb begin
    txreq_flit        = '0;
    txreq_flit.txnid  = TXNID_W'(req_idx);
    txreq_flit.srcid  = NODEID_W'(NODE_ID);
    txreq_flit.tgtid  = NODEID_W'(HNF_ID);
    txreq_flit.opcode = opcode_q[req_idx];
    txreq_flit.addr   = FLIT_ADDR_W'(addr_q[req_idx]);
    txrsp_flit        = '0;
    txrsp_flit.txnid  = TXNID_W'(ack_idx);
    txrsp_flit.srcid  = NODEID_W'(NODE_ID);
    txrsp_flit.tgtid  = NODEID_W'(NODE_ID);
    txrsp_flit.opcode = RSP_COMPACK;
  end

  // Each slot's case arm is keyed on its own current state, so one transition per cycle at most.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= S_IDLE;
        data_q[i]  <= '0;
      end
      proto_err_q  <= 1'b0;
      done_valid_q <= 1'b0;
      done_txnid_q <= '0;
      done_data_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        unique case (state_q[i])
          S_IDLE: if (alloc_fire && alloc_idx == IDX_W'(i)) begin
            state_q[i]  <= S_SEND_REQ;
            addr_q[i]   <= req_in_addr;
            opcode_q[i] <= req_in_opcode;
          end
          S_SEND_REQ: if (req_fire && req_idx == IDX_W'(i)) state_q[i] <= S_WAIT_DATA;
          S_WAIT_DATA: if (dat_hit && dat_idx == IDX_W'(i)) begin
            state_q[i] <= S_SEND_ACK;
            data_q[i]  <= rxdat_flit.data;
          end
          S_SEND_ACK: if (ack_fire && ack_idx == IDX_W'(i)) state_q[i] <= S_IDLE;
          default: state_q[i] <= S_IDLE;
        endcase
      end
      proto_err_q  <= proto_err_q | (rxdat_valid && !dat_hit);
      done_valid_q <= ack_fire;
      if (ack_fire) begin
        done_txnid_q <= ack_idx;
        done_data_q  <= data_q[ack_idx];
      end
    end
  end

  assign proto_err  = proto_err_q;
  assign done_valid = done_valid_q;
  assign done_txnid = done_txnid_q;
  assign done_data  = done_data_q;

`ifdef RNF_TRACKER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt_q [DEPTH];
  logic             timeout_err_q;

  // Flag rises on the same edge the counter reaches the limit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) wd_cnt_q[i] <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (req_fire && req_idx == IDX_W'(i)) begin
          wd_cnt_q[i] <= '0;
        end else if (wait_vec[i] && wd_cnt_q[i] != CNT_W'(TIMEOUT_CYCLES)) begin
          wd_cnt_q[i] <= wd_cnt_q[i] + 1'b1;
          if (wd_cnt_q[i] == CNT_W'(TIMEOUT_CYCLES - 1)) timeout_err_q <= 1'b1;
        end
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif
endmodule
